data_ram: RTL and testbench
===========================

DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 req  input  1  access request strobe from memory control; sampled only in IDLE.
REQ-004 rw  input  1  access type: 0 = read, 1 = write; X/Z ignored unless req=1.
REQ-005 addr  input  16  word address; valid range 0..15.
REQ-006 wdata  input  32  store data, used when rw=1.
REQ-007 rdata  output  32  registered read data, feeds the load-data path.
REQ-008 ack  output  1  one-cycle completion pulse for each accepted request.
REQ-009 busy  output  1  high while a request is in progress; upstream holds req until busy falls.
REQ-010 addr_err  output  1  qualifies ack; high when the accepted addr was out of range.

Function
REQ-011 Storage: 16 words x 32 bits, held in flops, indexed by addr[3:0].
REQ-012 FSM states and transitions:
- IDLE -> ACCESS when req=1 at a rising edge.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-013 On the IDLE->ACCESS edge, the block captures rw, addr and wdata into internal registers; later input changes have no effect on that access.
REQ-014 busy = 1 in ACCESS and RESP; busy = 0 in IDLE.
REQ-015 req is ignored in ACCESS and RESP: no queuing, no error.
REQ-016 Access timing: on the ACCESS->RESP edge the access is performed:
- write: mem[addr] <= wdata.
- read: rdata <= mem[addr].
REQ-017 ack = 1 exactly during the RESP cycle.
- Latency: ack is high in the second cycle after the sampling edge.
- Throughput: at most one access per 3 cycles.
REQ-018 Out of range (captured addr[15:4] != 0):
- no memory word changes.
- a read loads rdata with 0.
- addr_err = 1 during RESP.
- otherwise addr_err = 0.
REQ-019 rdata holds its value until the next completed read; a write leaves rdata unchanged.
REQ-020 A read of an address returns the last value written to it, including a write completed in the immediately preceding access.
REQ-021 addr_err is meaningful only while ack=1 and is 0 in all other cycles.

Reset
REQ-022 When rst_n=0, immediately and independent of clk:
- state = IDLE.
- all 16 memory words = 0.
- rdata = 0.
- ack = 0, busy = 0, addr_err = 0.
REQ-023 Reset during ACCESS or RESP abandons the access:
- no write commits after reset asserts.
- no ack is produced for the abandoned request.
REQ-024 After rst_n deasserts, a request can be sampled at the first rising edge.

Verification
REQ-025 Reset then read: rst_n pulse -> read addr 5 -> ack one cycle, rdata=0x00000000, addr_err=0.
REQ-026 Write then read: write 0xDEADBEEF to addr 3 -> ack, rdata unchanged; then read addr 3 -> rdata=0xDEADBEEF two cycles after sampling.
REQ-027 Out-of-range write: write 0x12345678 to addr 0x0010 -> ack with addr_err=1; read addr 0 -> 0x00000000, addr_err=0.
REQ-028 Busy and input changes:
- req held high with addr changed from 2 to 7 during ACCESS -> only addr 2 accessed, one ack.
- next request accepted only after busy=0.
REQ-029 Mid-access reset: write 0xA5A5A5A5 to addr 9, rst_n asserted during ACCESS -> no ack; read addr 9 after reset -> 0x00000000.
REQ-030 Back-to-back: writes 0x1..0xF to addr 1..15, then read all 16 -> addr 0 = 0, addr n = n, each ack spaced 3 cycles.

Source files
------------

// File: rtl/data_ram.sv
// data_ram: 16 x 32-bit flop-based data memory behind a three-state
// request/response handshake (IDLE -> ACCESS -> RESP -> IDLE).
//
// Ports
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   req      in   1   access request, sampled only in IDLE
//   rw       in   1   0 = read, 1 = write
//   addr     in  16   word address, valid 0..15
//   wdata    in  32   store data for writes
//   rdata    out 32   registered read data
//   ack      out  1   one-cycle completion pulse (RESP cycle)
//   busy     out  1   high in ACCESS and RESP
//   addr_err out  1   out-of-range flag, valid only with ack
module data_ram (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned IW    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Request fields captured on acceptance so later input changes are ignored.
  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state_q, state_d;
  req_t          req_q, req_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          addr_err_q, addr_err_d;

  logic [IW-1:0] idx;
  logic          out_of_range;

  assign idx          = req_q.addr[IW-1:0];
  assign out_of_range = (req_q.addr[AW-1:IW] != '0);

  // State, captured request, storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Next-state, access and output decode.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d     = ACCESS;
          req_d.rw    = rw;
          req_d.addr  = addr;
          req_d.wdata = wdata;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!out_of_range) begin
          if (req_q.rw) begin
            mem_d[idx] = req_q.wdata;
          end else begin
            rdata_d = mem_q[idx];
          end
        end else if (!req_q.rw) begin
          rdata_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the upcoming state so they align with it.
    busy_d     = (state_d != IDLE);
    ack_d      = (state_d == RESP);
    addr_err_d = (state_d == RESP) && (state_q == ACCESS) && out_of_range;
  end

  assign rdata    = rdata_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram.
module tb_data_ram;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        rw;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        addr_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ack_cyc = 0;
  logic [31:0] last_rd = 32'h0;

  data_ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .busy     (busy),
    .addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full access starting at a negedge in IDLE; returns at the negedge
  // after the response with the block idle again. Inputs are scrambled
  // after acceptance to confirm they were captured.
  task automatic access(input string tag, input logic w, input logic [15:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic exp_err);
    logic [31:0] want;
    req = 1'b1; rw = w; addr = a; wdata = d;
    @(posedge clk); @(negedge clk);
    chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
    chk({tag, "_ack_acc"},  32'(ack),  32'd0);
    req = 1'b0; rw = ~w; addr = ~a; wdata = ~d;
    @(posedge clk); @(negedge clk);
    want = w ? last_rd : exp_rd;
    chk({tag, "_ack"},   32'(ack),      32'd1);
    chk({tag, "_busy"},  32'(busy),     32'd1);
    chk({tag, "_err"},   32'(addr_err), 32'(exp_err));
    chk({tag, "_rdata"}, rdata,         want);
    ack_cyc = cyc;
    if (!w) last_rd = exp_rd;
    @(posedge clk); @(negedge clk);
    chk({tag, "_ack_end"},  32'(ack),      32'd0);
    chk({tag, "_busy_end"}, 32'(busy),     32'd0);
    chk({tag, "_err_end"},  32'(addr_err), 32'd0);
  endtask

  initial begin
    int prev;
    rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = 16'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack",   32'(ack), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_err",   32'(addr_err), 32'd0);
    rst_n = 1'b1;

    // Reset then read
    access("rd5_after_rst", 1'b0, 16'd5, 32'h0, 32'h0000_0000, 1'b0);

    // Write then read same address
    access("wr3", 1'b1, 16'd3, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access("rd3", 1'b0, 16'd3, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Out-of-range write then read addr 0; out-of-range read clears rdata
    access("wr_oor", 1'b1, 16'h0010, 32'h1234_5678, 32'h0, 1'b1);
    access("rd0",    1'b0, 16'd0, 32'h0, 32'h0000_0000, 1'b0);
    access("rd3b",   1'b0, 16'd3, 32'h0, 32'hDEAD_BEEF, 1'b0);
    access("rd_oor", 1'b0, 16'h8003, 32'h0, 32'h0000_0000, 1'b1);

    // Held req, addr changed during ACCESS: only addr 2 used, then 7 after idle
    access("wr2", 1'b1, 16'd2, 32'h2222_2222, 32'h0, 1'b0);
    access("wr7", 1'b1, 16'd7, 32'h7777_7777, 32'h0, 1'b0);
    req = 1'b1; rw = 1'b0; addr = 16'd2;
    @(posedge clk); @(negedge clk);
    chk("hold_busy1", 32'(busy), 32'd1);
    addr = 16'd7;
    @(posedge clk); @(negedge clk);
    chk("hold_ack1",   32'(ack), 32'd1);
    chk("hold_rdata1", rdata, 32'h2222_2222);
    @(posedge clk); @(negedge clk);
    chk("hold_ack_idle",  32'(ack),  32'd0);
    chk("hold_busy_idle", 32'(busy), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("hold_busy2", 32'(busy), 32'd1);
    chk("hold_ack2",  32'(ack),  32'd0);
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("hold_ack3",   32'(ack), 32'd1);
    chk("hold_rdata2", rdata, 32'h7777_7777);
    @(posedge clk); @(negedge clk);
    chk("hold_done", 32'(busy), 32'd0);
    last_rd = 32'h7777_7777;

    // Mid-access reset abandons write to 9
    req = 1'b1; rw = 1'b1; addr = 16'd9; wdata = 32'hA5A5_A5A5;
    @(posedge clk); @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_rdata", rdata, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    last_rd = 32'h0;
    access("rd9_after_rst", 1'b0, 16'd9, 32'h0, 32'h0000_0000, 1'b0);
    access("rd3_after_rst", 1'b0, 16'd3, 32'h0, 32'h0000_0000, 1'b0);

    // Back-to-back writes 1..15 then read all 16, acks every 3 cycles
    for (int n = 1; n < 16; n++) begin
      prev = ack_cyc;
      access("b2b_wr", 1'b1, 16'(n), 32'(n), 32'h0, 1'b0);
      if (n > 1) chk("b2b_wr_spacing", 32'(ack_cyc - prev), 32'd3);
    end
    for (int n = 0; n < 16; n++) begin
      prev = ack_cyc;
      access("b2b_rd", 1'b0, 16'(n), 32'h0, 32'(n), 1'b0);
      chk("b2b_rd_spacing", 32'(ack_cyc - prev), 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
